radix4_seq_multiplier: RTL

- Parametrised unsigned sequential multiplier. Next generation of the team's 2x2 gate-level multiplier cell.
- Retires two multiplier bits per clock: a radix-4 digit, i.e. a 2-bit by WIDTH-bit partial product.
- Runs one operation at a time under a start/busy/done handshake, so wide products (8..32 bit) use far less area than a flat combinational array.
- Sits in the arithmetic datapath as a shared multiply resource for control FSMs.

---
 rtl/radix4_seq_multiplier.sv | 136 +++++++++++++
 1 files changed

// File: rtl/radix4_seq_multiplier.sv
// Unsigned sequential multiplier that retires one radix-4 digit (two multiplier
// bits) per clock under a start/busy/done handshake.
module radix4_seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int STEPS = WIDTH / 2;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam int PW    = 2 * WIDTH;
   localparam int PPW   = WIDTH + 2;

   if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("radix4_seq_multiplier: WIDTH must be even and >= 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [PW-1:0]    acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [PW-1:0]    p_q;

   logic [PPW-1:0]   pp_d;
   logic [PW-1:0]    acc_d;
   logic             last_d;

   // Partial product of the multiplicand and one radix-4 digit: 0, a, 2a or 3a.
   function automatic logic [PPW-1:0] digit_pp(input logic [WIDTH-1:0] m, input logic [1:0] d);
      logic [PPW-1:0] m1;
      logic [PPW-1:0] m2;
      m1 = {2'b00, m};
      m2 = {1'b0, m, 1'b0};
      case (d)
         2'd0:    digit_pp = '0;
         2'd1:    digit_pp = m1;
         2'd2:    digit_pp = m2;
         2'd3:    digit_pp = m2 + m1;
         default: digit_pp = '0;
      endcase
   endfunction

   // Next accumulator value: add the current digit's product at weight 4^cnt.
   always_comb begin
      pp_d   = digit_pp(a_q, b_sh_q[1:0]);
      acc_d  = acc_q + (PW'(pp_d) << {cnt_q, 1'b0});
      last_d = (cnt_q == CNT_W'(STEPS - 1));
   end

   // Control FSM together with the datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         p_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_sh_q  <= b;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               acc_q  <= acc_d;
               b_sh_q <= b_sh_q >> 2;
               cnt_q  <= cnt_q + CNT_W'(1);
               if (last_d) begin
                  p_q     <= acc_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  state_q <= RUN;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               // A start in the done cycle is taken immediately for back-to-back use.
               if (start) begin
                  a_q     <= a;
                  b_sh_q  <= b;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign p    = p_q;

endmodule
